chacha_driver: RTL
==================

CHACHA_DRIVER -- requirements
Module: chacha_driver

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 cfg_valid  in  1  host config byte valid.
REQ-005 cfg_sel  in  2  field select: 0 key, 1 nonce, 2 counter, 3 reserved.
REQ-006 cfg_data  in  8  config byte, little-endian within field.
REQ-007 cfg_ready  out  1  config byte accepted when cfg_valid&cfg_ready.
REQ-008 pt_valid / pt_data[7:0] / pt_ready  in/in/out  plaintext byte stream.
REQ-009 ct_valid / ct_data[7:0] / ct_ready  out/out/in  ciphertext byte stream.
REQ-010 wr_key, wr_nnc, wr_ctr  out  1 each  core write strobes; core samples data_in on every cycle its strobe is high.
REQ-011 core_din  out  8  byte driven to core data_in.
REQ-012 blk_ready  in  1  core keystream block available.
REQ-013 rd_blk  out  1  core read strobe; each high cycle consumes the byte currently on core_dout.
REQ-014 core_dout  in  8  core keystream byte at current address.
REQ-015 ctr_wrap  out  1  sticky: block counter overflowed.

Function
REQ-016 States SHALL be IDLE, WAIT, STREAM, CTR_UPD, HALT.
REQ-017 Field lengths SHALL be key 32, nonce 12, counter 4 bytes; per-field byte counter and done flag.
REQ-018 cfg_ready SHALL be high in IDLE, WAIT, HALT; low in STREAM, CTR_UPD.
REQ-019 Accepted byte, sel 0..2: matching wr_* high that cycle, core_din=cfg_data, combinational.
REQ-020 Accepted sel=3 byte SHALL be dropped, no strobe.
REQ-021 Byte for a different field than previous accepted byte SHALL restart that field count at 0, clear its done flag.
REQ-022 Counter bytes SHALL also load a 32-bit shadow counter at byte position.
REQ-023 Any accepted config byte SHALL move WAIT to IDLE; HALT left only by completed counter field.
REQ-024 IDLE->WAIT when key, nonce, counter done flags all set.
REQ-025 WAIT SHALL ignore blk_ready for 2 cycles after entry, then ->STREAM when blk_ready=1.
REQ-026 STREAM: pt_ready=ct_ready, ct_valid=pt_valid, ct_data=pt_data^core_dout, rd_blk=pt_valid&ct_ready, all combinational.
REQ-027 A 6-bit byte index SHALL advance per transfer; transfer at index 63 -> CTR_UPD, index wraps to 0.
REQ-028 CTR_UPD: shadow+1 SHALL be written to core as 4 consecutive wr_ctr cycles, LSB first, then ->WAIT.
REQ-029 Shadow 0xFFFFFFFF at block end: shadow wraps to 0, ctr_wrap=1, ->HALT, no counter write.
REQ-030 HALT: counter done flag clear; new full counter field clears ctr_wrap, ->WAIT.
REQ-031 pt_ready, ct_valid, rd_blk, wr_* SHALL be 0 in all states except as stated above.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, clear counts, done flags, shadow, index, ctr_wrap.
REQ-033 During reset: strobes, rd_blk, pt_ready, ct_valid, ct_data, core_din, ctr_wrap =0; cfg_ready=1.
REQ-034 Reset mid-block or mid-CTR_UPD SHALL abandon the transfer; full reload required.

Structure
REQ-035 Shared package SHALL hold state enum, field-select codes, field lengths (32/12/4), block length 64.
REQ-036 One sub-module chacha_field_cnt (per-field byte counter + done flag) SHALL be instantiated 3 times.

Verification
REQ-037 Load key 00..1F, nonce 00..0B, counter 01 00 00 00 -> wr_key 32, wr_nnc 12, wr_ctr 4 cycles, ->WAIT.
REQ-038 blk_ready=1, 64 pt bytes 0x00, ct_ready=1 -> ct_data equals core_dout, 64 rd_blk, then wr_ctr bytes 02 00 00 00.
REQ-039 ct_ready toggled 1-0 during stream -> rd_blk only on accepted cycles, no byte lost or duplicated.
REQ-040 Counter FF FF FF FF, one block -> ctr_wrap=1, HALT, no wr_ctr; load 00 00 00 00 -> ctr_wrap=0, WAIT.
REQ-041 Key bytes 0..9 then nonce byte -> key done clear, stays IDLE until full key rewritten.
REQ-042 rst_n low at index 30 -> all outputs reset same cycle, IDLE, cfg_ready=1.

Source files
------------

// File: rtl/chacha_driver_pkg.sv
// Shared definitions for the ChaCha core driver: FSM states, config field
// select codes and the field/block byte lengths.
package chacha_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_STREAM  = 3'd2,
    ST_CTR_UPD = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [1:0] SEL_KEY = 2'd0;
  localparam logic [1:0] SEL_NNC = 2'd1;
  localparam logic [1:0] SEL_CTR = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  localparam int unsigned KEY_LEN  = 32;
  localparam int unsigned NNC_LEN  = 12;
  localparam int unsigned CTR_LEN  = 4;
  localparam int unsigned BLK_LEN  = 64;
  localparam int unsigned WAIT_CYC = 2;
  localparam int unsigned POS_W    = 5;

endpackage

// File: rtl/chacha_field_cnt.sv
// Byte counter and done flag for one config field; a restart forces the
// current byte to position 0 and drops any earlier completion.
module chacha_field_cnt
  import chacha_driver_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic             i_restart,
  input  logic             i_clr_done,
  output logic [POS_W-1:0] o_pos,
  output logic             o_done
);

  logic [POS_W-1:0] r_cnt;
  logic             r_done;
  logic             w_last;

  assign o_pos  = i_restart ? '0 : r_cnt;
  assign w_last = (o_pos == POS_W'(LEN - 1));
  assign o_done = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_wr) begin
      r_cnt  <= w_last ? '0 : o_pos + POS_W'(1);
      r_done <= w_last | (r_done & ~i_restart);
    end else if (i_clr_done) begin
      r_done <= 1'b0;
    end
  end

endmodule

// File: rtl/chacha_driver.sv
// Drives a ChaCha keystream core: forwards host key/nonce/counter bytes,
// XORs plaintext with keystream and advances the block counter per block.
module chacha_driver
  import chacha_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_sel,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  input  logic       pt_valid,
  input  logic [7:0] pt_data,
  output logic       pt_ready,
  output logic       ct_valid,
  output logic [7:0] ct_data,
  input  logic       ct_ready,
  output logic       wr_key,
  output logic       wr_nnc,
  output logic       wr_ctr,
  output logic [7:0] core_din,
  input  logic       blk_ready,
  output logic       rd_blk,
  input  logic [7:0] core_dout,
  output logic       ctr_wrap
);

  state_t           r_state;
  logic [1:0]       r_last_sel;
  logic [31:0]      r_shadow;
  logic [5:0]       r_idx;
  logic [1:0]       r_wait_cnt;
  logic [1:0]       r_upd_idx;
  logic             r_ctr_wrap;

  logic             w_cfg_rdy;
  logic             w_accept;
  logic             w_restart;
  logic [2:0]       w_fld_wr;
  logic [2:0]       w_done;
  logic [POS_W-1:0] w_key_pos;
  logic [POS_W-1:0] w_nnc_pos;
  logic [POS_W-1:0] w_ctr_pos;
  logic [POS_W-1:0] w_pos_sel;
  logic             w_xfer;
  logic             w_blk_end;
  logic             w_wrap_now;

  assign w_cfg_rdy   = (r_state == ST_IDLE) || (r_state == ST_WAIT) || (r_state == ST_HALT);
  // rst_n gating keeps strobes quiet while reset is held with cfg_valid high
  assign w_accept    = cfg_valid & w_cfg_rdy & rst_n;
  assign w_restart   = (cfg_sel != r_last_sel);
  assign w_fld_wr[0] = w_accept && (cfg_sel == SEL_KEY);
  assign w_fld_wr[1] = w_accept && (cfg_sel == SEL_NNC);
  assign w_fld_wr[2] = w_accept && (cfg_sel == SEL_CTR);
  assign w_xfer      = (r_state == ST_STREAM) && pt_valid && ct_ready;
  assign w_blk_end   = w_xfer && (r_idx == 6'(BLK_LEN - 1));
  assign w_wrap_now  = w_blk_end && (&r_shadow);
  assign cfg_ready   = w_cfg_rdy;
  assign ctr_wrap    = r_ctr_wrap;

  chacha_field_cnt #(.LEN(KEY_LEN)) u_key_cnt (
    .clk(clk), .rst_n(rst_n), .i_wr(w_fld_wr[0]), .i_restart(w_restart),
    .i_clr_done(1'b0), .o_pos(w_key_pos), .o_done(w_done[0])
  );
  chacha_field_cnt #(.LEN(NNC_LEN)) u_nnc_cnt (
    .clk(clk), .rst_n(rst_n), .i_wr(w_fld_wr[1]), .i_restart(w_restart),
    .i_clr_done(1'b0), .o_pos(w_nnc_pos), .o_done(w_done[1])
  );
  chacha_field_cnt #(.LEN(CTR_LEN)) u_ctr_cnt (
    .clk(clk), .rst_n(rst_n), .i_wr(w_fld_wr[2]), .i_restart(w_restart),
    .i_clr_done(w_wrap_now), .o_pos(w_ctr_pos), .o_done(w_done[2])
  );

  always_comb begin
    case (cfg_sel)
      SEL_KEY: w_pos_sel = w_key_pos;
      SEL_NNC: w_pos_sel = w_nnc_pos;
      default: w_pos_sel = w_ctr_pos;
    endcase
  end

  // Core-facing and stream outputs; config strobes pass straight through
  always_comb begin
    pt_ready = 1'b0;
    ct_valid = 1'b0;
    ct_data  = '0;
    rd_blk   = 1'b0;
    wr_key   = w_fld_wr[0];
    wr_nnc   = w_fld_wr[1];
    wr_ctr   = w_fld_wr[2];
    core_din = (w_accept && (cfg_sel != SEL_RSV)) ? cfg_data : '0;
    case (r_state)
      ST_STREAM: begin
        pt_ready = ct_ready;
        ct_valid = pt_valid;
        ct_data  = pt_data ^ core_dout;
        rd_blk   = pt_valid & ct_ready;
      end
      ST_CTR_UPD: begin
        wr_ctr   = 1'b1;
        core_din = r_shadow[{r_upd_idx, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_sel <= SEL_RSV;
      r_shadow   <= '0;
      r_idx      <= '0;
      r_wait_cnt <= '0;
      r_upd_idx  <= '0;
      r_ctr_wrap <= 1'b0;
    end else begin
      if (w_accept && (cfg_sel != SEL_RSV)) r_last_sel <= cfg_sel;
      if (w_fld_wr[2] && (w_pos_sel < POS_W'(CTR_LEN)))
        r_shadow[{w_pos_sel[1:0], 3'b000} +: 8] <= cfg_data;
      case (r_state)
        ST_IDLE: begin
          if ((&w_done) && !w_accept) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (w_accept) r_state <= ST_IDLE;
          else if (r_wait_cnt < 2'(WAIT_CYC)) r_wait_cnt <= r_wait_cnt + 2'd1;
          else if (blk_ready) r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_xfer) r_idx <= r_idx + 6'd1;
          if (w_wrap_now) begin
            r_shadow   <= '0;
            r_ctr_wrap <= 1'b1;
            r_state    <= ST_HALT;
          end else if (w_blk_end) begin
            r_shadow  <= r_shadow + 32'd1;
            r_upd_idx <= '0;
            r_state   <= ST_CTR_UPD;
          end
        end
        ST_CTR_UPD: begin
          r_upd_idx <= r_upd_idx + 2'd1;
          if (r_upd_idx == 2'(CTR_LEN - 1)) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end
        end
        ST_HALT: begin
          if (w_done[2]) begin
            r_ctr_wrap <= 1'b0;
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
